// File: rtl/term_ctrl.sv
// Text terminal controller: buffers keystrokes in a small FIFO and turns them into
// video-memory cell writes, tracking the cursor and a circular scroll base.
module term_ctrl #(
  parameter int COLS       = 70,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  output logic       key_ready,
  output logic       overflow,
  output logic       wr_en,
  output logic [6:0] wr_x,
  output logic [4:0] wr_y,
  output logic [7:0] wr_data,
  output logic [4:0] scroll_base,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [6:0]    LAST_X  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_Y  = 5'(ROWS - 1);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    SPACE   = 8'h20;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        state_r;
  logic [6:0]    fill_x_r;
  logic [4:0]    fill_y_r;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;

  logic          act_write_s;
  logic [6:0]    act_x_s;
  logic [4:0]    act_row_s;
  logic [7:0]    act_data_s;
  logic [6:0]    new_x_s;
  logic [4:0]    new_y_s;
  logic          adv_s;
  logic          scroll_s;

  // Wrap a logical row onto the circular physical row space without exceeding ROWS-1.
  function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= 6'(ROWS)) begin
      phys_row = 5'(sum - 6'(ROWS));
    end else begin
      phys_row = sum[4:0];
    end
  endfunction

  assign push_s = key_valid && key_ready;
  assign pop_s  = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
  assign head_s = fifo_mem_r[rd_ptr_r];

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Key FIFO storage, pointers, registered ready and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_r  <= {PW{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      key_ready <= 1'b1;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= key_ascii;
        wr_ptr_r <= (wr_ptr_r == LAST_P) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_P) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r   <= count_nxt_s;
      key_ready <= (count_nxt_s != FULL_C);
      overflow  <= overflow | (key_valid & ~key_ready);
    end
  end

  // Decode the FIFO head into a cell write and the next cursor position.
  always_comb begin
    act_write_s = 1'b0;
    act_x_s     = cur_x;
    act_row_s   = cur_y;
    act_data_s  = SPACE;
    new_x_s     = cur_x;
    new_y_s     = cur_y;
    adv_s       = 1'b0;
    scroll_s    = 1'b0;
    if ((head_s >= 8'h20) && (head_s <= 8'h7E)) begin
      act_write_s = 1'b1;
      act_data_s  = head_s;
      if (cur_x == LAST_X) begin
        new_x_s = 7'd0;
        adv_s   = 1'b1;
      end else begin
        new_x_s = cur_x + 7'd1;
      end
    end else if ((head_s == 8'h0A) || (head_s == 8'h0D)) begin
      new_x_s = 7'd0;
      adv_s   = 1'b1;
    end else if (head_s == 8'h08) begin
      if (cur_x != 7'd0) begin
        new_x_s     = cur_x - 7'd1;
        act_x_s     = cur_x - 7'd1;
        act_write_s = 1'b1;
      end else if (cur_y != 5'd0) begin
        new_x_s     = LAST_X;
        new_y_s     = cur_y - 5'd1;
        act_x_s     = LAST_X;
        act_row_s   = cur_y - 5'd1;
        act_write_s = 1'b1;
      end else begin
        act_write_s = 1'b0;
      end
    end else begin
      act_write_s = 1'b0;
    end
    // Line-advance on the bottom row scrolls instead of moving the cursor.
    if (adv_s) begin
      if (cur_y != LAST_Y) begin
        new_y_s = cur_y + 5'd1;
      end else begin
        scroll_s = 1'b1;
      end
    end else begin
      scroll_s = 1'b0;
    end
  end

  // Main FSM: screen fill after reset, key processing, and bottom-row clear after scroll.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_INIT;
      fill_x_r    <= 7'd0;
      fill_y_r    <= 5'd0;
      wr_en       <= 1'b0;
      wr_x        <= 7'd0;
      wr_y        <= 5'd0;
      wr_data     <= 8'h00;
      scroll_base <= 5'd0;
      cur_x       <= 7'd0;
      cur_y       <= 5'd0;
      busy        <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          wr_en   <= 1'b1;
          wr_x    <= fill_x_r;
          wr_y    <= fill_y_r;
          wr_data <= SPACE;
          if (fill_x_r == LAST_X) begin
            fill_x_r <= 7'd0;
            if (fill_y_r == LAST_Y) begin
              fill_y_r <= 5'd0;
              state_r  <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              fill_y_r <= fill_y_r + 5'd1;
            end
          end else begin
            fill_x_r <= fill_x_r + 7'd1;
          end
        end
        ST_IDLE: begin
          if (pop_s) begin
            wr_en   <= act_write_s;
            wr_x    <= act_x_s;
            wr_y    <= phys_row(scroll_base, act_row_s);
            wr_data <= act_data_s;
            cur_x   <= new_x_s;
            cur_y   <= new_y_s;
            if (scroll_s) begin
              // The new physical bottom row is the row that used to be on top.
              scroll_base <= (scroll_base == LAST_Y) ? 5'd0 : scroll_base + 5'd1;
              fill_x_r    <= 7'd0;
              fill_y_r    <= scroll_base;
              state_r     <= ST_CLEAR;
              busy        <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            wr_en <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wr_en   <= 1'b1;
          wr_x    <= fill_x_r;
          wr_y    <= fill_y_r;
          wr_data <= SPACE;
          if (fill_x_r == LAST_X) begin
            fill_x_r <= 7'd0;
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            fill_x_r <= fill_x_r + 7'd1;
          end
        end
        default: begin
          state_r  <= ST_INIT;
          fill_x_r <= 7'd0;
          fill_y_r <= 5'd0;
          wr_en    <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: table of keys with expected writes/cursor,
// plus sequences for init fill, scroll/clear, overflow and reset during clear.
module tb_term_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic       key_ready;
  logic       overflow;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [4:0] wr_y;
  logic [7:0] wr_data;
  logic [4:0] scroll_base;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  term_ctrl #(.COLS(70), .ROWS(30), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
    .key_ready(key_ready), .overflow(overflow), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .scroll_base(scroll_base), .cur_x(cur_x),
    .cur_y(cur_y), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] y;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] key;
    logic       wr;
    logic [6:0] wx;
    logic [4:0] wy;
    logic [7:0] wd;
    logic [6:0] ex;
    logic [4:0] ey;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[16];
  int   checks = 0;
  int   errors = 0;
  logic sb_on = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic exp_write(input logic [6:0] x, input logic [4:0] y, input logic [7:0] d);
    wr_t e;
    e.x = x; e.y = y; e.d = d;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score any write on the output bus.
  task automatic tick();
    wr_t e;
    @(negedge clock);
    if (!reset && sb_on && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got x=%0d y=%0d d=%h expected no write", wr_x, wr_y, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_cell got x=%0d y=%0d d=%h expected x=%0d y=%0d d=%h",
                   wr_x, wr_y, wr_data, e.x, e.y, e.d);
        end
      end
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    int guard;
    guard = 0;
    while (!key_ready && guard < 300) begin
      tick();
      guard++;
    end
    check("key_ready_wait", {31'd0, key_ready}, 32'd1);
    key_valid = 1'b1;
    key_ascii = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic check_cursor(input string name, input logic [6:0] x, input logic [4:0] y);
    check({name, "_x"}, {25'd0, cur_x}, {25'd0, x});
    check({name, "_y"}, {27'd0, cur_y}, {27'd0, y});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_key_ready"}, {31'd0, key_ready}, 32'd1);
    check({name, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({name, "_scroll"}, {27'd0, scroll_base}, 32'd0);
    check({name, "_wr_bus"}, {12'd0, wr_x, wr_y, wr_data}, 32'd0);
    check_cursor(name, 7'd0, 5'd0);
  endtask

  task automatic expect_init();
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 70; x++) begin
        exp_write(7'(x), 5'(y), 8'h20);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{8'h08, 1'b0, 7'd0,  5'd0, 8'h00, 7'd0,  5'd0};
    tbl[1]  = '{8'h41, 1'b1, 7'd0,  5'd0, 8'h41, 7'd1,  5'd0};
    tbl[2]  = '{8'h42, 1'b1, 7'd1,  5'd0, 8'h42, 7'd2,  5'd0};
    tbl[3]  = '{8'h0D, 1'b0, 7'd0,  5'd0, 8'h00, 7'd0,  5'd1};
    tbl[4]  = '{8'h68, 1'b1, 7'd0,  5'd1, 8'h68, 7'd1,  5'd1};
    tbl[5]  = '{8'h07, 1'b0, 7'd0,  5'd0, 8'h00, 7'd1,  5'd1};
    tbl[6]  = '{8'h7F, 1'b0, 7'd0,  5'd0, 8'h00, 7'd1,  5'd1};
    tbl[7]  = '{8'h7E, 1'b1, 7'd1,  5'd1, 8'h7E, 7'd2,  5'd1};
    tbl[8]  = '{8'h08, 1'b1, 7'd1,  5'd1, 8'h20, 7'd1,  5'd1};
    tbl[9]  = '{8'h08, 1'b1, 7'd0,  5'd1, 8'h20, 7'd0,  5'd1};
    tbl[10] = '{8'h08, 1'b1, 7'd69, 5'd0, 8'h20, 7'd69, 5'd0};
    tbl[11] = '{8'h20, 1'b1, 7'd69, 5'd0, 8'h20, 7'd0,  5'd1};
    tbl[12] = '{8'h0A, 1'b0, 7'd0,  5'd0, 8'h00, 7'd0,  5'd2};
    tbl[13] = '{8'h00, 1'b0, 7'd0,  5'd0, 8'h00, 7'd0,  5'd2};
    tbl[14] = '{8'h1F, 1'b0, 7'd0,  5'd0, 8'h00, 7'd0,  5'd2};
    tbl[15] = '{8'h30, 1'b1, 7'd0,  5'd2, 8'h30, 7'd1,  5'd2};

    // Reset state and power-up screen fill.
    repeat (2) tick();
    check_reset_outputs("reset");
    expect_init();
    reset = 1'b0;
    tick();
    check("init_busy", {31'd0, busy}, 32'd1);
    drain(2300);
    check("init_done_busy", {31'd0, busy}, 32'd0);
    check("init_done_wr_en", {31'd0, wr_en}, 32'd0);

    // Table of single keys.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) exp_write(tbl[i].wx, tbl[i].wy, tbl[i].wd);
      send_key(tbl[i].key);
      drain(50);
      check_cursor($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey);
    end

    // Backspace from column 0 of row 5.
    send_key(8'h0D);
    send_key(8'h0A);
    send_key(8'h0A);
    drain(50);
    check_cursor("to_row5", 7'd0, 5'd5);
    exp_write(7'd69, 5'd4, 8'h20);
    send_key(8'h08);
    drain(50);
    check_cursor("bs_up", 7'd69, 5'd4);

    // Walk to (69,29), then wrap-scroll with a printable character.
    send_key(8'h0D);
    for (int i = 0; i < 24; i++) send_key(8'h0A);
    drain(200);
    check_cursor("to_row29", 7'd0, 5'd29);
    check("no_scroll_yet", {27'd0, scroll_base}, 32'd0);
    for (int i = 0; i < 69; i++) begin
      exp_write(7'(i), 5'd29, 8'h78);
      send_key(8'h78);
    end
    exp_write(7'd69, 5'd29, 8'h5A);
    for (int i = 0; i < 70; i++) exp_write(7'(i), 5'd0, 8'h20);
    send_key(8'h5A);
    drain(500);
    check("scroll1", {27'd0, scroll_base}, 32'd1);
    check_cursor("after_wrap", 7'd0, 5'd29);

    // Bottom logical row now maps to physical row 0; newline scrolls again.
    exp_write(7'd0, 5'd0, 8'h71);
    send_key(8'h71);
    drain(50);
    check_cursor("after_q", 7'd1, 5'd29);
    for (int i = 0; i < 70; i++) exp_write(7'(i), 5'd1, 8'h20);
    send_key(8'h0A);
    drain(200);
    check("scroll2", {27'd0, scroll_base}, 32'd2);
    check_cursor("after_nl_scroll", 7'd0, 5'd29);

    // Reset in the middle of a clear.
    sb_on = 1'b0;
    send_key(8'h0A);
    begin
      int n;
      n = 0;
      while (!(wr_en && busy && wr_x == 7'd30) && n < 60) begin
        tick();
        n++;
      end
    end
    check("clear_x30_seen", {20'd0, wr_en, wr_x, wr_y}, {20'd1, 7'd30, 5'd2});
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_clear_reset");
    repeat (2) tick();
    exp_q.delete();
    expect_init();
    for (int i = 0; i < 4; i++) exp_write(7'(i), 5'd0, 8'h61 + 8'(i));
    sb_on = 1'b1;
    reset = 1'b0;
    repeat (10) tick();

    // Five back-to-back keys while the fill is still running.
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_ascii = 8'h61 + 8'(i);
      tick();
      if (i == 2) check("ready_at_3", {31'd0, key_ready}, 32'd1);
      if (i == 3) check("ready_full", {31'd0, key_ready}, 32'd0);
      if (i == 4) check("overflow_set", {31'd0, overflow}, 32'd1);
    end
    key_valid = 1'b0;
    check("busy_during_init", {31'd0, busy}, 32'd1);
    drain(2300);
    check_cursor("after_fifo_keys", 7'd4, 5'd0);
    check("ready_again", {31'd0, key_ready}, 32'd1);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    check("scroll_reset", {27'd0, scroll_base}, 32'd0);

    // Burst with push and pop in the same cycles.
    for (int i = 0; i < 6; i++) begin
      exp_write(7'(4 + i), 5'd0, 8'h72 + 8'(i));
      send_key(8'h72 + 8'(i));
    end
    drain(100);
    check_cursor("after_burst", 7'd10, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 Parameter COLS, 70, number of text columns; cursor x range 0..COLS-1.
REQ-002 Parameter ROWS, 30, number of text rows; cursor y range 0..ROWS-1.
REQ-003 Parameter FIFO_DEPTH, 4, key FIFO entries (power of two).
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 key_valid  in  1  key_ascii present this cycle.
REQ-007 key_ascii  in  8  ASCII code from keyboard decoder.
REQ-008 key_ready  out  1  FIFO not full; a push is accepted only when key_valid && key_ready.
REQ-009 overflow  out  1  sticky; set when key_valid && !key_ready.
REQ-010 wr_en  out  1  video-memory write strobe, one cell per cycle.
REQ-011 wr_x  out  7  write column.
REQ-012 wr_y  out  5  write physical row.
REQ-013 wr_data  out  8  character written.
REQ-014 scroll_base  out  5  physical row displayed at screen top.
REQ-015 cur_x  out  7  logical cursor column.
REQ-016 cur_y  out  5  logical cursor row.
REQ-017 busy  out  1  high in INIT or CLEAR.

Function
REQ-018 Physical row SHALL be (scroll_base + logical row) mod ROWS, computed without overflow past ROWS-1.
REQ-019 States SHALL be INIT, IDLE, CLEAR; all outputs registered.
REQ-020 INIT: wr_en high for ROWS*COLS consecutive cycles, wr_data 0x20, raster order (y 0..ROWS-1, x 0..COLS-1 within each row); then go to IDLE.
REQ-021 FIFO SHALL accept pushes in every state; pops occur only in IDLE.
REQ-022 IDLE with FIFO non-empty: pop one entry per cycle; the resulting write (if any) appears on wr_* exactly one cycle after the pop.
REQ-023 Printable 0x20..0x7E: write char at (cur_x, phys(cur_y)); cur_x+1; if cur_x was COLS-1, cur_x=0 and line-advance.
REQ-024 0x0A or 0x0D: cur_x=0 and line-advance; no write.
REQ-025 0x08: if cur_x>0, cur_x-1 and write 0x20 at new position; if cur_x==0 && cur_y>0, cur_y-1, cur_x=COLS-1, write 0x20 there; at (0,0) no action.
REQ-026 Any other code SHALL be discarded without a write or cursor change.
REQ-027 Line-advance: if cur_y<ROWS-1, cur_y+1; else cur_y unchanged, scroll_base+1 mod ROWS, enter CLEAR.
REQ-028 CLEAR: wr_en high for COLS consecutive cycles, wr_y = new physical bottom row, wr_x 0..COLS-1, wr_data 0x20; no pops; return to IDLE.
REQ-029 A printable char causing wrap-scroll SHALL complete its own write before the CLEAR cycles start.
REQ-030 Simultaneous push and pop with FIFO full: push refused (key_ready from registered count); pop proceeds.
REQ-031 Simultaneous push and pop with FIFO non-full: count unchanged, both succeed, order preserved.
REQ-032 wr_en SHALL be low in every cycle not specified above.

Reset
REQ-033 On reset assertion, immediately: state INIT with counters 0, FIFO empty, key_ready 1, overflow 0, wr_en 0, wr_x/wr_y/wr_data 0, scroll_base 0, cur_x 0, cur_y 0, busy 1.
REQ-034 Reset mid-INIT or mid-CLEAR SHALL abort the operation and restart INIT from cell (0,0) after release.

Verification
REQ-035 Release reset -> busy high, 2100 writes of 0x20 in raster order, then busy 0 and wr_en 0.
REQ-036 After INIT, push 'A'(0x41),'B',0x0D -> writes (0,0)=0x41, (1,0)=0x42, cursor ends (0,1).
REQ-037 Cursor (69,29), push 0x5A -> write (69,29)=0x5A, then 70 writes of 0x20 to physical row 0, scroll_base=1, cursor (0,29).
REQ-038 Cursor (0,5), push 0x08 -> write 0x20 at (69, phys 4), cursor (69,4); at (0,0) push 0x08 -> no write.
REQ-039 During INIT push 5 keys -> key_ready low after 4, overflow set, first 4 keys processed in order afterwards.
REQ-040 Assert reset during CLEAR at x=30 -> outputs reset immediately; full INIT restarts at (0,0).
